uart_rx_sequencer: RTL

Frame sequencer for the UART receiver peripheral. It watches the synchronized serial line, detects start bits, and times the mid-bit sample points from a programmable bit period. It assembles the data bits and reports frame completion and errors to the APB register/FIFO logic. Internally it uses a bit-period timer and a bit counter as its datapath, both controlled by one FSM.

---
 rtl/uart_rx_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sequencer.sv
// ============================================================================
// Module  : uart_rx_sequencer
// Purpose : UART receive frame sequencer. Detects start bits, times mid-bit
//           samples from a programmable bit period, assembles data bits and
//           reports frame completion / framing / parity errors.
// Options : RX_PARITY_EN adds an even-parity bit between data and stop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sequencer #(
  parameter int TIMER_BITS = 14
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  serial_in,
  input  logic                  rx_enable,
  input  logic [TIMER_BITS-1:0] bit_period,
  input  logic [3:0]            data_size,
  output logic                  shift_strobe,
  output logic [7:0]            rx_data,
  output logic                  packet_done,
  output logic                  framing_error,
  output logic                  parity_error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [TIMER_BITS-1:0] c_timer_one  = TIMER_BITS'(1);
  localparam logic [TIMER_BITS-1:0] c_min_period = TIMER_BITS'(4);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_prev_line;
  logic [TIMER_BITS-1:0]   r_timer;
  logic [TIMER_BITS-1:0]   r_period;
  logic [3:0]              r_size;
  logic [3:0]              r_bitcnt;
  logic [7:0]              r_rx_data;
  logic                    r_stop_bad;

  logic                    w_start;
  logic                    w_abort;
  logic                    w_in_frame;
  logic [TIMER_BITS-1:0]   w_target;
  logic                    w_terminal;
  logic                    w_last_bit;
  logic [TIMER_BITS-1:0]   w_period_clamped;
  logic [3:0]              w_size_clamped;

  assign w_in_frame = (r_state == START_CHK) || (r_state == DATA) ||
                      (r_state == PARITY)    || (r_state == STOP);
  assign w_start    = r_prev_line & ~serial_in & rx_enable &
                      ((r_state == IDLE) || (r_state == DONE));
  // A completed frame in DONE is not aborted, so rx_data survives the drop.
  assign w_abort    = w_in_frame & ~rx_enable;

  assign w_target   = (r_state == START_CHK) ? (r_period >> 1) : r_period;
  assign w_terminal = w_in_frame && (r_timer == (w_target - c_timer_one));
  assign w_last_bit = ((r_bitcnt + 4'd1) == r_size);

  assign w_period_clamped = (bit_period < c_min_period) ? c_min_period : bit_period;
  assign w_size_clamped   = ((data_size < 4'd5) || (data_size > 4'd8)) ? 4'd8 : data_size;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_next_state = START_CHK;
      end
      START_CHK: begin
        if (w_abort)         w_next_state = IDLE;
        else if (w_terminal) w_next_state = serial_in ? IDLE : DATA;
      end
      DATA: begin
        if (w_abort) begin
          w_next_state = IDLE;
        end else if (w_terminal && w_last_bit) begin
`ifdef RX_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end
      end
      PARITY: begin
        if (w_abort)         w_next_state = IDLE;
        else if (w_terminal) w_next_state = STOP;
      end
      STOP: begin
        if (w_abort)         w_next_state = IDLE;
        else if (w_terminal) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = w_start ? START_CHK : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_prev_line <= 1'b1;
      r_timer     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_prev_line <= serial_in;
      // Timer restarts on every state entry and at every bit boundary.
      if ((w_next_state != r_state) || w_terminal || (r_state == IDLE))
        r_timer <= '0;
      else
        r_timer <= r_timer + c_timer_one;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_period   <= c_min_period;
      r_size     <= 4'd8;
      r_bitcnt   <= 4'd0;
      r_rx_data  <= 8'h00;
      r_stop_bad <= 1'b0;
    end else begin
      if (w_start) begin
        r_period  <= w_period_clamped;
        r_size    <= w_size_clamped;
        r_bitcnt  <= 4'd0;
        r_rx_data <= 8'h00;
      end else if (w_abort) begin
        r_rx_data <= 8'h00;
      end else if ((r_state == DATA) && w_terminal) begin
        r_rx_data[r_bitcnt[2:0]] <= serial_in;
        r_bitcnt                 <= r_bitcnt + 4'd1;
      end
      if ((r_state == STOP) && w_terminal && !w_abort)
        r_stop_bad <= ~serial_in;
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_bad;

  // Unreceived MSBs are zero, so reducing the whole byte is exact.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_par_bad <= 1'b0;
    else if ((r_state == PARITY) && w_terminal && !w_abort)
      r_par_bad <= (^r_rx_data) ^ serial_in;
  end

  assign parity_error = (r_state == DONE) & r_par_bad;
`else
  assign parity_error = 1'b0;
`endif

  assign shift_strobe  = (r_state == DATA) & w_terminal;
  assign rx_data       = r_rx_data;
  assign packet_done   = (r_state == DONE);
  assign framing_error = (r_state == DONE) & r_stop_bad;
  assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire
